// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the instruction ROM: IDLE/RUN/DONE control,
// sequential/absolute/relative PC updates, stall, halt and a retired-instruction counter.
module fetch_ctrl #(
    parameter int          D          = 12,
    parameter int unsigned START_ADDR = 0,
    parameter int          CW         = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_stall,
    input  logic          i_br_taken,
    input  logic          i_br_rel,
    input  logic [D-1:0]  i_br_addr,
    input  logic [7:0]    i_br_off,
    input  logic          i_halt_req,
    input  logic [8:0]    i_mach_code,
    output logic [D-1:0]  o_prog_ctr,
    output logic [8:0]    o_instr,
    output logic          o_instr_valid,
    output logic          o_running,
    output logic          o_done,
    output logic [CW-1:0] o_instr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [D-1:0]  r_prog_ctr;
    logic [CW-1:0] r_count;
    logic          r_running;
    logic          r_done;
    logic          r_valid;

    logic [D-1:0]  w_off_ext;
    logic [CW-1:0] w_count_inc;

    // Offset is sign-extended so a relative branch can move backwards; the add wraps mod 2**D.
    assign w_off_ext   = D'($signed(i_br_off));
    assign w_count_inc = (r_count == {CW{1'b1}}) ? r_count : r_count + CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_prog_ctr <= '0;
            r_count    <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state    <= S_RUN;
                        r_prog_ctr <= D'(START_ADDR);
                        r_count    <= '0;
                        r_running  <= 1'b1;
                        r_done     <= 1'b0;
                        r_valid    <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A stall freezes everything, including a pending halt or branch.
                    if (!i_stall) begin
                        r_count <= w_count_inc;
                        if (i_halt_req) begin
                            r_state   <= S_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                            r_valid   <= 1'b0;
                        end else if (i_br_taken && i_br_rel) begin
                            r_prog_ctr <= r_prog_ctr + w_off_ext;
                        end else if (i_br_taken) begin
                            r_prog_ctr <= i_br_addr;
                        end else begin
                            r_prog_ctr <= r_prog_ctr + D'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                    r_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign o_prog_ctr    = r_prog_ctr;
    assign o_instr       = i_mach_code;
    assign o_instr_valid = r_valid;
    assign o_running     = r_running;
    assign o_done        = r_done;
    assign o_instr_count = r_count;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter sequencer for the 9-bit instruction ROM. Drives the ROM address (prog_ctr) and forwards the returned machine code to the decoder with a valid flag.
- Applies sequential, absolute-branch and relative-branch PC updates, plus stall and halt requests from downstream.
- Runs a start/done handshake with the testbench/top level and keeps a retired-instruction counter.

Parameters:
D, 12, ROM address width (ROM depth 2**D)
START_ADDR, 0, PC value loaded on each start
CW, 16, width of instr_count

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin execution pulse; honoured only in IDLE or DONE
stall  input  1  freeze PC and counter this cycle
br_taken  input  1  branch taken for the current instruction
br_rel  input  1  1 = relative branch (use br_off), 0 = absolute (use br_addr)
br_addr  input  D  absolute branch target
br_off  input  8  signed two's-complement PC offset
halt_req  input  1  current instruction is the halt/done instruction
mach_code  input  9  instruction word from ROM at prog_ctr (combinational ROM)
prog_ctr  output  D  ROM address, registered
instr  output  9  instruction to decoder (= mach_code)
instr_valid  output  1  instr is live and executing this cycle
running  output  1  FSM in RUN
done  output  1  FSM in DONE
instr_count  output  CW  instructions retired since last start, saturating

Behaviour:
- FSM states: IDLE, RUN, DONE. prog_ctr and instr_count are registers. instr is a combinational pass-through of mach_code.
- Reset (sync, any state, overrides all inputs): state IDLE, prog_ctr 0, instr_count 0, running 0, done 0, instr_valid 0.
- IDLE:
  - instr_valid 0.
  - start=1 -> RUN next cycle, prog_ctr<=START_ADDR, instr_count<=0.
  - All other inputs ignored.
- RUN:
  - instr_valid=1; running=1.
  - Per-cycle priority, highest first:
    1. stall=1: prog_ctr and instr_count hold; br_*/halt_req ignored.
    2. halt_req=1: state<=DONE, prog_ctr holds, instr_count+1.
    3. br_taken & br_rel: prog_ctr<=prog_ctr + sign_extend(br_off) modulo 2**D, instr_count+1.
    4. br_taken & !br_rel: prog_ctr<=br_addr, instr_count+1.
    5. Otherwise: prog_ctr<=prog_ctr+1 modulo 2**D, instr_count+1.
  - start ignored in RUN.
- DONE:
  - done=1, instr_valid 0, prog_ctr and instr_count hold (readable by bench).
  - start=1 -> RUN, prog_ctr<=START_ADDR, instr_count<=0, done deasserts next cycle.
- Latency: a new PC takes effect the cycle after the deciding inputs. One instruction issues per non-stalled RUN cycle; there are no bubbles after branches.
- Wrap-around:
  - Sequential increment from 2**D-1 goes to 0.
  - A relative branch past either end wraps modulo 2**D.
  - Neither case is an error.
- instr_count saturates at 2**CW-1 and does not wrap.
- halt_req together with br_taken: halt wins, PC not redirected. Stall together with halt_req: nothing happens; the halt is taken on the first non-stalled cycle.
- Reset mid-RUN discards state: IDLE next cycle, prog_ctr 0, count 0.

Test Plan:
- Reset then start=1 (START_ADDR=0), 5 cycles no branch -> prog_ctr 0,1,2,3,4,5; instr tracks mach_code each cycle; instr_valid=1; instr_count=5.
- At prog_ctr=10, br_taken=1 br_rel=1 br_off=8'hFB -> next prog_ctr=5. At prog_ctr=2, br_off=8'hF0 (D=12) -> prog_ctr=4082 (wrap).
- At prog_ctr=7, br_taken=1 br_rel=0 br_addr=12'h123 -> prog_ctr=0x123. Separately, prog_ctr=4095 with no branch -> next 0.
- stall=1 held 3 cycles at prog_ctr=6 with br_taken=1 -> prog_ctr stays 6, count unchanged. Release with br_taken=0 -> prog_ctr=7.
- halt_req=1 and br_taken=1 at prog_ctr=20 -> DONE, done=1, prog_ctr stays 20, instr_valid=0, count includes halt. Then start=1 -> RUN at START_ADDR, count 0.
- reset=1 during RUN at prog_ctr=50 -> next cycle IDLE, prog_ctr=0, count=0, running=0. start ignored while reset high.
